// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver on the 25 MHz clock domain.
// The rx pin goes through a 2-FF synchroniser, a per-bit counter times each bit,
// and the line is sampled at mid-bit. The byte is offered on a valid/ack handshake
// with one-cycle framing and overrun error pulses.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic       clk_25mhz,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ack,
    output logic       busy,
    output logic       framing_err,
    output logic       overrun_err
);

    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned BW   = 3;

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(7);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic          rx_meta;
    logic          rx_s;

    logic [CW-1:0] cnt;
    logic [BW-1:0] bit_idx;
    logic [7:0]    shreg;

    logic          cnt_clr;
    logic          cnt_inc;
    logic          bit_clr;
    logic          bit_inc;
    logic          shift_en;
    logic          load_byte;
    logic          ferr_set;
    logic          oerr_set;
    logic          slot_free;

    logic          cnt_at_half;
    logic          cnt_at_last;

    assign cnt_at_half = (cnt == CNT_HALF);
    assign cnt_at_last = (cnt == CNT_LAST);

    // An ack on the load edge empties the slot before the new byte lands.
    assign slot_free = !data_valid || data_ack;

    // Two-stage synchroniser for the asynchronous rx pin; idles high.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (cnt_at_half) begin
                    state_nxt = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_at_last && (bit_idx == BIT_LAST)) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_at_last) begin
                    state_nxt = rx_s ? ST_IDLE : ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: datapath strobes and the busy flag.
    always_comb begin
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        bit_clr   = 1'b0;
        bit_inc   = 1'b0;
        shift_en  = 1'b0;
        load_byte = 1'b0;
        ferr_set  = 1'b0;
        oerr_set  = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                busy    = 1'b0;
                cnt_clr = 1'b1;
            end
            ST_START: begin
                if (cnt_at_half) begin
                    cnt_clr = 1'b1;
                    bit_clr = !rx_s;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_at_last) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    bit_inc  = (bit_idx != BIT_LAST);
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_at_last) begin
                    cnt_clr = 1'b1;
                    if (!rx_s) begin
                        ferr_set = 1'b1;
                    end else if (slot_free) begin
                        load_byte = 1'b1;
                    end else begin
                        oerr_set = 1'b1;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_WAIT_HIGH: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Bit timer, bit index and LSB-first shift register.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= 8'h00;
        end else begin
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CW'(1);
            end

            if (bit_clr) begin
                bit_idx <= '0;
            end else if (bit_inc) begin
                bit_idx <= bit_idx + BW'(1);
            end

            if (shift_en) begin
                shreg <= {rx_s, shreg[7:1]};
            end
        end
    end

    // Output holding register, valid/ack handshake and error pulses.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            data        <= 8'h00;
            data_valid  <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            framing_err <= ferr_set;
            overrun_err <= oerr_set;
            if (load_byte) begin
                data       <= shreg;
                data_valid <= 1'b1;
            end else if (data_ack) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a frame-level reference model.
module tb_uart_rx;

    localparam int unsigned N         = 16;
    localparam int unsigned HALF      = N / 2;
    // Edge on which a frame's byte loads, counted from the first edge after the start bit is driven.
    localparam int          LOAD_EDGE = 2 + 1 + HALF + 9 * N;

    logic       clk_25mhz = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ack;
    logic       busy;
    logic       framing_err;
    logic       overrun_err;

    uart_rx #(.CLKS_PER_BIT(N)) dut (
        .clk_25mhz  (clk_25mhz),
        .reset      (reset),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .busy       (busy),
        .framing_err(framing_err),
        .overrun_err(overrun_err)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    int vectors     = 0;
    int miscompares = 0;

    // Observed activity.
    int         ferr_cnt   = 0;
    int         oerr_cnt   = 0;
    logic [7:0] got_q[$];
    bit         prev_valid = 1'b0;
    bit         prev_ack   = 1'b0;

    // Reference model: one holding slot, byte outcome decided per frame.
    logic [7:0] exp_q[$];
    logic [7:0] m_data = 8'h00;
    bit         m_full = 1'b0;
    int         m_ferr = 0;
    int         m_oerr = 0;

    int         lat;
    int         lat_a;
    int         lat_b;
    int         busy_cnt;
    logic [7:0] rnd_byte;
    bit         rnd_stop;

    function automatic void model_frame(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            m_ferr++;
        end else if (m_full) begin
            m_oerr++;
        end else begin
            m_data = b;
            m_full = 1'b1;
            exp_q.push_back(b);
        end
    endfunction

    function automatic void model_ack();
        m_full = 1'b0;
    endfunction

    function automatic void model_reset();
        m_full = 1'b0;
        m_data = 8'h00;
    endfunction

    // Monitor: count error pulse cycles and log each newly presented byte.
    always @(negedge clk_25mhz) begin
        if (framing_err === 1'b1) ferr_cnt++;
        if (overrun_err === 1'b1) oerr_cnt++;
        if (data_valid === 1'b1 && (!prev_valid || prev_ack)) got_q.push_back(data);
        prev_valid = (data_valid === 1'b1);
        prev_ack   = (data_ack === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        vectors++;
        assert (obs >= lo && obs <= hi) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_25mhz);
            #5;
        end
    endtask

    task automatic align();
        @(posedge clk_25mhz);
        #5;
    endtask

    task automatic sample();
        @(negedge clk_25mhz);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(N);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(N);
        end
        rx = stop_bit;
        tick(N);
    endtask

    task automatic ack_pulse();
        data_ack = 1'b1;
        tick(1);
        data_ack = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (data_valid !== 1'b1 && cycles < 400) begin
            @(negedge clk_25mhz);
            cycles++;
        end
    endtask

    task automatic check_model_state(input string tag);
        check({tag, "_data"}, 32'(data), 32'(m_data));
        check({tag, "_valid"}, 32'(data_valid), 32'(m_full));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, 32'(data), 32'h00);
        check({tag, "_valid"}, 32'(data_valid), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_ferr"}, 32'(framing_err), 32'h0);
        check({tag, "_oerr"}, 32'(overrun_err), 32'h0);
    endtask

    initial begin
        #3200000;
        $display("FAIL watchdog: simulation did not finish, observed running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rx       = 1'b1;
        data_ack = 1'b0;
        reset    = 1'b1;

        // Reset values.
        tick(3);
        sample();
        check_reset_outputs("reset");
        align();
        reset = 1'b0;
        tick(5);

        // 0xA5 delivered about 9.5 bit times after the start edge and held.
        fork
            send_frame(8'hA5, 1'b1);
            wait_valid(lat);
        join
        model_frame(8'hA5, 1'b1);
        check_range("a5_latency", lat, 150, 162);
        tick(50);
        sample();
        check_model_state("a5_hold");
        check("a5_ferr", 32'(ferr_cnt), 32'(m_ferr));
        check("a5_oerr", 32'(oerr_cnt), 32'(m_oerr));
        align();
        ack_pulse();
        model_ack();
        sample();
        check("a5_acked_valid", 32'(data_valid), 32'h0);

        // 0x00 then 0xFF back-to-back, each acked promptly.
        align();
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
            end
            begin
                wait_valid(lat_a);
                align();
                tick(int'($urandom_range(0, 15)));
                ack_pulse();
                wait_valid(lat_b);
                align();
                tick(int'($urandom_range(0, 15)));
                ack_pulse();
            end
            begin
                wait_valid(lat);
                busy_cnt = 0;
                repeat (100) begin
                    if (busy === 1'b0) busy_cnt++;
                    @(negedge clk_25mhz);
                end
            end
        join
        model_frame(8'h00, 1'b1);
        model_ack();
        model_frame(8'hFF, 1'b1);
        model_ack();
        check_range("b2b_busy_gap", busy_cnt, 6, 10);
        sample();
        check("b2b_valid", 32'(data_valid), 32'h0);
        check("b2b_busy", 32'(busy), 32'h0);
        check("b2b_ferr", 32'(ferr_cnt), 32'(m_ferr));

        // 0x3C with a low stop bit, line held low, then recovery and 0x81.
        align();
        send_frame(8'h3C, 1'b0);
        model_frame(8'h3C, 1'b0);
        tick(40);
        sample();
        check("frm_ferr", 32'(ferr_cnt), 32'(m_ferr));
        check("frm_valid", 32'(data_valid), 32'h0);
        check("frm_wait_busy", 32'(busy), 32'h1);
        align();
        rx = 1'b1;
        tick(4);
        sample();
        check("frm_recover_busy", 32'(busy), 32'h0);
        align();
        send_frame(8'h81, 1'b1);
        model_frame(8'h81, 1'b1);
        sample();
        check_model_state("frm_next");
        align();
        ack_pulse();
        model_ack();

        // Short low glitch on an idle line.
        tick(5);
        fork
            begin
                rx = 1'b0;
                tick(4);
                rx = 1'b1;
                tick(30);
            end
            begin
                busy_cnt = 0;
                repeat (34) begin
                    @(negedge clk_25mhz);
                    if (busy === 1'b1) busy_cnt++;
                end
            end
        join
        check_range("glitch_busy", busy_cnt, 6, 10);
        sample();
        check("glitch_valid", 32'(data_valid), 32'h0);
        check("glitch_ferr", 32'(ferr_cnt), 32'(m_ferr));
        check("glitch_oerr", 32'(oerr_cnt), 32'(m_oerr));

        // 0x11 unacked, 0x22 overruns; then ack lands on the 0x33 load edge.
        align();
        send_frame(8'h11, 1'b1);
        model_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        model_frame(8'h22, 1'b1);
        sample();
        check("ovr_oerr", 32'(oerr_cnt), 32'(m_oerr));
        check_model_state("ovr_keep");
        align();
        fork
            send_frame(8'h33, 1'b1);
            begin
                tick(LOAD_EDGE - 1);
                data_ack = 1'b1;
                tick(1);
                data_ack = 1'b0;
            end
        join
        model_ack();
        model_frame(8'h33, 1'b1);
        sample();
        check_model_state("ack_on_load");
        check("ack_on_load_oerr", 32'(oerr_cnt), 32'(m_oerr));

        // Reset during bit 4 of 0xC3, then 0x5A.
        align();
        fork
            send_frame(8'hC3, 1'b1);
            begin
                tick(2 + 1 + int'(HALF) + 4 * int'(N) + int'(HALF));
                reset = 1'b1;
            end
        join
        sample();
        check_reset_outputs("mid_reset");
        model_reset();
        align();
        reset = 1'b0;
        tick(5);
        send_frame(8'h5A, 1'b1);
        model_frame(8'h5A, 1'b1);
        sample();
        check_model_state("post_reset");
        align();
        ack_pulse();
        model_ack();

        // Random bytes, occasional bad stop bits, random consumer behaviour.
        for (int f = 0; f < 40; f++) begin
            rnd_byte = 8'($urandom_range(0, 255));
            rnd_stop = ($urandom_range(0, 5) != 0);
            align();
            send_frame(rnd_byte, rnd_stop);
            model_frame(rnd_byte, rnd_stop);
            sample();
            check_model_state("rnd");
            align();
            rx = 1'b1;
            if ($urandom_range(0, 3) != 0) begin
                ack_pulse();
                model_ack();
            end
            tick(rnd_stop ? int'($urandom_range(0, 3)) : 2 + int'($urandom_range(0, 3)));
        end

        // Totals against the model.
        tick(5);
        sample();
        check("total_ferr", 32'(ferr_cnt), 32'(m_ferr));
        check("total_oerr", 32'(oerr_cnt), 32'(m_oerr));
        check("total_bytes", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check("byte_order", (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(exp_q[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
